hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/neocore_pkg.sv | 39 +++
 rtl/hazard_scoreboard_if.sv | 57 +++++
 rtl/hazard_scoreboard_issue_prefix_sel.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 165 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/neocore_pkg.sv
// Shared width helpers and forward-code encoding for the hazard scoreboard.
// Contents:
//   rw_width   - register address width for a register count
//   lw_width   - countdown width able to hold 0..max_lat
//   fw_width   - operand-select width for stages*issue_w writers + rf + long unit
//   fwd_encode - select code for in-flight writer (stage s, slot k)
//   fwd_lc     - select code for the long-unit writeback port
package neocore_pkg;

    localparam int unsigned FWD_RF = 0;

    function automatic int unsigned rw_width(input int unsigned num_regs);
        int unsigned w;
        w = $clog2(num_regs);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned lw_width(input int unsigned max_lat);
        int unsigned w;
        w = $clog2(max_lat + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned fw_width(input int unsigned stages, input int unsigned issue_w);
        int unsigned w;
        w = $clog2(stages * issue_w + 2);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned fwd_encode(input int unsigned s, input int unsigned k,
                                               input int unsigned issue_w);
        return 1 + s * issue_w + k;
    endfunction

    function automatic int unsigned fwd_lc(input int unsigned stages, input int unsigned issue_w);
        return stages * issue_w + 1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Bundle of all ID-stage, in-flight-writer and result signals of the hazard scoreboard.
// master: pipeline side (drives ID bundle, stage writers, hold/flush; receives selects/issue).
// slave : scoreboard side.
interface hazard_scoreboard_if
    import neocore_pkg::*;
#(
    parameter int unsigned ISSUE_W  = 2,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned STAGES   = 3,
    parameter int unsigned MAX_LAT  = 8
);
    localparam int unsigned RW = rw_width(NUM_REGS);
    localparam int unsigned LW = lw_width(MAX_LAT);
    localparam int unsigned FW = fw_width(STAGES, ISSUE_W);

    // ID bundle
    logic [ISSUE_W-1:0]                   id_valid;
    logic [ISSUE_W-1:0]                   id_rd_we;
    logic [ISSUE_W-1:0]                   id_mem_read;
    logic [ISSUE_W-1:0]                   id_long;
    logic [ISSUE_W-1:0][RW-1:0]           id_rs1;
    logic [ISSUE_W-1:0][RW-1:0]           id_rs2;
    logic [ISSUE_W-1:0][RW-1:0]           id_rd;
    logic [ISSUE_W-1:0][LW-1:0]           id_long_lat;
    // in-flight writers and long-unit writeback
    logic [STAGES-1:0][ISSUE_W-1:0]         st_valid;
    logic [STAGES-1:0][ISSUE_W-1:0]         st_rd_we;
    logic [STAGES-1:0][ISSUE_W-1:0][RW-1:0] st_rd;
    logic                                   lc_valid;
    logic [RW-1:0]                          lc_rd;
    // pipeline control
    logic                                   pipe_hold;
    logic                                   flush;
    // results
    logic [ISSUE_W-1:0][FW-1:0]           fwd_a;
    logic [ISSUE_W-1:0][FW-1:0]           fwd_b;
    logic [ISSUE_W-1:0]                   issue_mask;
    logic                                 stall;
    logic                                 flush_ex;
    logic                                 split;
    logic [NUM_REGS-1:0]                  sb_busy;
    logic [31:0]                          perf_stall;
    logic [31:0]                          perf_split;

    modport master (
        output id_valid, id_rd_we, id_mem_read, id_long, id_rs1, id_rs2, id_rd, id_long_lat,
        output st_valid, st_rd_we, st_rd, lc_valid, lc_rd, pipe_hold, flush,
        input  fwd_a, fwd_b, issue_mask, stall, flush_ex, split, sb_busy, perf_stall, perf_split
    );

    modport slave (
        input  id_valid, id_rd_we, id_mem_read, id_long, id_rs1, id_rs2, id_rd, id_long_lat,
        input  st_valid, st_rd_we, st_rd, lc_valid, lc_rd, pipe_hold, flush,
        output fwd_a, fwd_b, issue_mask, stall, flush_ex, split, sb_busy, perf_stall, perf_split
    );

endinterface

// File: rtl/hazard_scoreboard_issue_prefix_sel.sv
// issue_prefix_sel: combines scoreboard hazards with intra-bundle dependences and
// selects the longest in-order prefix of valid, hazard-free slots.
// Ports:
//   valid, rd_we, rs1, rs2, rd - per-slot ID decode
//   sb_haz                     - per-slot scoreboard hazard (busy rs1/rs2/rd)
//   block                      - hold or flush: nothing issues
//   hazard_c                   - per-slot combined hazard
//   issue_mask_c               - issued prefix
module issue_prefix_sel #(
    parameter int unsigned ISSUE_W = 2,
    parameter int unsigned RW      = 4
) (
    input  logic [ISSUE_W-1:0]         valid,
    input  logic [ISSUE_W-1:0]         rd_we,
    input  logic [ISSUE_W-1:0][RW-1:0] rs1,
    input  logic [ISSUE_W-1:0][RW-1:0] rs2,
    input  logic [ISSUE_W-1:0][RW-1:0] rd,
    input  logic [ISSUE_W-1:0]         sb_haz,
    input  logic                       block,
    output logic [ISSUE_W-1:0]         hazard_c,
    output logic [ISSUE_W-1:0]         issue_mask_c
);

    logic run;

    // Older slot j writing anything slot k touches (RAW or WAW) serialises k behind j.
    always_comb begin
        hazard_c     = sb_haz;
        issue_mask_c = '0;
        run          = 1'b1;
        for (int k = 0; k < ISSUE_W; k++) begin
            for (int j = 0; j < k; j++) begin
                if (valid[j] && rd_we[j] && (rd[j] != '0)) begin
                    if ((rd[j] == rs1[k]) || (rd[j] == rs2[k]) ||
                        (rd_we[k] && (rd[j] == rd[k]))) begin
                        hazard_c[k] = 1'b1;
                    end
                end
            end
            run             = run & valid[k] & ~hazard_c[k];
            issue_mask_c[k] = run & ~block;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: multi-issue ID-stage hazard unit. Keeps a per-register
// countdown of outstanding load/long-op results, selects forwarding sources,
// decides the issued prefix of the bundle and raises stall/split.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - hazard_scoreboard_if.slave (ID bundle, stage writers, results)
// Optional feature: define HAZARD_SCOREBOARD_PERF_EN for saturating stall/split
// counters; otherwise perf_stall/perf_split are tied to zero.
module hazard_scoreboard
    import neocore_pkg::*;
#(
    parameter int unsigned ISSUE_W  = 2,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned STAGES   = 3,
    parameter int unsigned MAX_LAT  = 8,
    parameter int unsigned LD_LAT   = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    hazard_scoreboard_if.slave  bus
);

    localparam int unsigned RW = rw_width(NUM_REGS);
    localparam int unsigned LW = lw_width(MAX_LAT);
    localparam int unsigned FW = fw_width(STAGES, ISSUE_W);

    logic [NUM_REGS-1:0][LW-1:0] cnt_q;
    logic [NUM_REGS-1:0][LW-1:0] cnt_nxt;
    logic [ISSUE_W-1:0]          sb_haz_c;
    logic [ISSUE_W-1:0]          hazard_c;
    logic [ISSUE_W-1:0]          issue_mask_c;
    logic [ISSUE_W-1:0][FW-1:0]  fwd_a_c;
    logic [ISSUE_W-1:0][FW-1:0]  fwd_b_c;
    logic                        stall_c;
    logic                        split_c;

    function automatic logic [LW-1:0] clamp_lat(input logic [LW-1:0] lat);
        if (lat == '0) begin
            return LW'(1);
        end else if (lat > LW'(MAX_LAT)) begin
            return LW'(MAX_LAT);
        end
        return lat;
    endfunction

    // Operand source select: written lowest priority first so later writes win
    // (lc < higher stage < lower stage; within a stage the higher slot wins).
    always_comb begin
        fwd_a_c = '0;
        fwd_b_c = '0;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            if (bus.lc_valid) begin
                if (bus.lc_rd == bus.id_rs1[k]) fwd_a_c[k] = FW'(fwd_lc(STAGES, ISSUE_W));
                if (bus.lc_rd == bus.id_rs2[k]) fwd_b_c[k] = FW'(fwd_lc(STAGES, ISSUE_W));
            end
            for (int unsigned si = 0; si < STAGES; si++) begin
                for (int unsigned j = 0; j < ISSUE_W; j++) begin
                    if (bus.st_valid[STAGES-1-si][j] && bus.st_rd_we[STAGES-1-si][j]) begin
                        if (bus.st_rd[STAGES-1-si][j] == bus.id_rs1[k])
                            fwd_a_c[k] = FW'(fwd_encode(STAGES-1-si, j, ISSUE_W));
                        if (bus.st_rd[STAGES-1-si][j] == bus.id_rs2[k])
                            fwd_b_c[k] = FW'(fwd_encode(STAGES-1-si, j, ISSUE_W));
                    end
                end
            end
            // r0 is hardwired: always read from the register file
            if (bus.id_rs1[k] == '0) fwd_a_c[k] = FW'(FWD_RF);
            if (bus.id_rs2[k] == '0) fwd_b_c[k] = FW'(FWD_RF);
        end
    end

    // Scoreboard hazard per slot; cnt_q[0] is held at zero so r0 never hazards.
    always_comb begin
        sb_haz_c = '0;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            sb_haz_c[k] = (cnt_q[bus.id_rs1[k]] != '0) ||
                          (cnt_q[bus.id_rs2[k]] != '0) ||
                          (bus.id_rd_we[k] && (cnt_q[bus.id_rd[k]] != '0));
        end
    end

    issue_prefix_sel #(
        .ISSUE_W (ISSUE_W),
        .RW      (RW)
    ) u_prefix (
        .valid        (bus.id_valid),
        .rd_we        (bus.id_rd_we),
        .rs1          (bus.id_rs1),
        .rs2          (bus.id_rs2),
        .rd           (bus.id_rd),
        .sb_haz       (sb_haz_c),
        .block        (bus.pipe_hold | bus.flush),
        .hazard_c     (hazard_c),
        .issue_mask_c (issue_mask_c)
    );

    assign stall_c = bus.id_valid[0] & hazard_c[0] & ~bus.pipe_hold & ~bus.flush;
    assign split_c = (issue_mask_c != '0) && (issue_mask_c != bus.id_valid);

    // Countdown next state: decrement when not held, then issued sets override.
    // Flush only suppresses new sets; outstanding ops still retire.
    always_comb begin
        cnt_nxt = cnt_q;
        if (!bus.pipe_hold) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (cnt_q[r] != '0) cnt_nxt[r] = cnt_q[r] - LW'(1);
            end
        end
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            if (issue_mask_c[k] && bus.id_rd_we[k] && (bus.id_rd[k] != '0)) begin
                if (bus.id_long[k]) begin
                    cnt_nxt[bus.id_rd[k]] = clamp_lat(bus.id_long_lat[k]);
                end else if (bus.id_mem_read[k]) begin
                    cnt_nxt[bus.id_rd[k]] = LW'(LD_LAT);
                end
            end
        end
        cnt_nxt[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

    always_comb begin
        bus.sb_busy = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            bus.sb_busy[r] = (cnt_q[r] != '0);
        end
    end

    assign bus.fwd_a      = fwd_a_c;
    assign bus.fwd_b      = fwd_b_c;
    assign bus.issue_mask = issue_mask_c;
    assign bus.stall      = stall_c;
    assign bus.flush_ex   = stall_c;
    assign bus.split      = split_c;

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_split_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_split_q <= '0;
        end else begin
            if (stall_c && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
            if (split_c && (perf_split_q != '1)) perf_split_q <= perf_split_q + 32'd1;
        end
    end

    assign bus.perf_stall = perf_stall_q;
    assign bus.perf_split = perf_split_q;
`else
    assign bus.perf_stall = '0;
    assign bus.perf_split = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// random bundles, all compared against a behavioural model of the issue rules.
module tb_hazard_scoreboard;

    localparam int ISSUE_W  = 2;
    localparam int NUM_REGS = 16;
    localparam int STAGES   = 3;
    localparam int MAX_LAT  = 8;
    localparam int LD_LAT   = 1;
    localparam int RW       = $clog2(NUM_REGS);
    localparam int LW       = $clog2(MAX_LAT + 1);
    localparam int FW       = $clog2(STAGES * ISSUE_W + 2);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(
        .ISSUE_W(ISSUE_W), .NUM_REGS(NUM_REGS), .STAGES(STAGES), .MAX_LAT(MAX_LAT)
    ) bus ();

    hazard_scoreboard #(
        .ISSUE_W(ISSUE_W), .NUM_REGS(NUM_REGS), .STAGES(STAGES),
        .MAX_LAT(MAX_LAT), .LD_LAT(LD_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // model state: remaining busy cycles per register, event counts
    int          mcnt [NUM_REGS];
    logic [31:0] m_perf_stall;
    logic [31:0] m_perf_split;

    // expectations for the current cycle
    logic [ISSUE_W-1:0]         e_mask;
    logic                       e_stall;
    logic                       e_split;
    logic [ISSUE_W-1:0][FW-1:0] e_fa;
    logic [ISSUE_W-1:0][FW-1:0] e_fb;
    logic [NUM_REGS-1:0]        e_busy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit busy_ref(input int r);
        return (r != 0) && (mcnt[r] > 0);
    endfunction

    // Source priority list walked in order: EX..WB, higher slot first in a stage, then lc.
    function automatic int fwd_ref(input int rs);
        if (rs == 0) return 0;
        for (int s = 0; s < STAGES; s++)
            for (int k = ISSUE_W - 1; k >= 0; k--)
                if (bus.st_valid[s][k] && bus.st_rd_we[s][k] && int'(bus.st_rd[s][k]) == rs)
                    return 1 + s * ISSUE_W + k;
        if (bus.lc_valid && int'(bus.lc_rd) == rs) return STAGES * ISSUE_W + 1;
        return 0;
    endfunction

    task automatic compute_expect();
        bit wr [NUM_REGS];
        bit blocked, hz, hz0;
        int rs1, rs2, rd;
        for (int r = 0; r < NUM_REGS; r++) wr[r] = 1'b0;
        blocked = 1'b0;
        hz0     = 1'b0;
        e_mask  = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            rs1 = int'(bus.id_rs1[k]);
            rs2 = int'(bus.id_rs2[k]);
            rd  = int'(bus.id_rd[k]);
            hz = busy_ref(rs1) || busy_ref(rs2) || (bus.id_rd_we[k] && busy_ref(rd)) ||
                 wr[rs1] || wr[rs2] || (bus.id_rd_we[k] && wr[rd]);
            if (k == 0) hz0 = hz;
            if (!blocked && bus.id_valid[k] && !hz) e_mask[k] = 1'b1;
            else blocked = 1'b1;
            if (bus.id_valid[k] && bus.id_rd_we[k] && rd != 0) wr[rd] = 1'b1;
            e_fa[k] = FW'(fwd_ref(rs1));
            e_fb[k] = FW'(fwd_ref(rs2));
        end
        if (bus.pipe_hold || bus.flush) e_mask = '0;
        e_stall = bus.id_valid[0] && hz0 && !bus.pipe_hold && !bus.flush;
        e_split = (e_mask != '0) && (e_mask != bus.id_valid);
        for (int r = 0; r < NUM_REGS; r++) e_busy[r] = busy_ref(r);
    endtask

    task automatic compare_all(input string where);
        compute_expect();
        check({where, "/issue_mask"}, bus.issue_mask, e_mask);
        check({where, "/stall"},      bus.stall,      e_stall);
        check({where, "/flush_ex"},   bus.flush_ex,   e_stall);
        check({where, "/split"},      bus.split,      e_split);
        check({where, "/fwd_a"},      bus.fwd_a,      e_fa);
        check({where, "/fwd_b"},      bus.fwd_b,      e_fb);
        check({where, "/sb_busy"},    bus.sb_busy,    e_busy);
`ifdef HAZARD_SCOREBOARD_PERF_EN
        check({where, "/perf_stall"}, bus.perf_stall, m_perf_stall);
        check({where, "/perf_split"}, bus.perf_split, m_perf_split);
`else
        check({where, "/perf_stall"}, bus.perf_stall, 32'd0);
        check({where, "/perf_split"}, bus.perf_split, 32'd0);
`endif
    endtask

    task automatic model_clear();
        for (int r = 0; r < NUM_REGS; r++) mcnt[r] = 0;
        m_perf_stall = '0;
        m_perf_split = '0;
    endtask

    task automatic model_update();
        int rd, lat;
        if (!rst_n) begin
            model_clear();
            return;
        end
        if (!bus.pipe_hold)
            for (int r = 0; r < NUM_REGS; r++) if (mcnt[r] > 0) mcnt[r] = mcnt[r] - 1;
        for (int k = 0; k < ISSUE_W; k++) begin
            rd = int'(bus.id_rd[k]);
            if (e_mask[k] && bus.id_rd_we[k] && rd != 0) begin
                if (bus.id_long[k]) begin
                    lat = int'(bus.id_long_lat[k]);
                    if (lat < 1) lat = 1;
                    if (lat > MAX_LAT) lat = MAX_LAT;
                    mcnt[rd] = lat;
                end else if (bus.id_mem_read[k]) begin
                    mcnt[rd] = LD_LAT;
                end
            end
        end
        if (e_stall && m_perf_stall != 32'hFFFF_FFFF) m_perf_stall = m_perf_stall + 1;
        if (e_split && m_perf_split != 32'hFFFF_FFFF) m_perf_split = m_perf_split + 1;
    endtask

    task automatic sample(input string where);
        @(negedge clk);
        compare_all(where);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid    = '0;
        bus.id_rd_we    = '0;
        bus.id_mem_read = '0;
        bus.id_long     = '0;
        bus.id_rs1      = '0;
        bus.id_rs2      = '0;
        bus.id_rd       = '0;
        bus.id_long_lat = '0;
        bus.st_valid    = '0;
        bus.st_rd_we    = '0;
        bus.st_rd       = '0;
        bus.lc_valid    = 1'b0;
        bus.lc_rd       = '0;
        bus.pipe_hold   = 1'b0;
        bus.flush       = 1'b0;
    endtask

    task automatic set_slot(input int k, input bit v, input int rs1, input int rs2, input int rd,
                            input bit we, input bit ld, input bit lg, input int lat);
        bus.id_valid[k]    = v;
        bus.id_rs1[k]      = RW'(rs1);
        bus.id_rs2[k]      = RW'(rs2);
        bus.id_rd[k]       = RW'(rd);
        bus.id_rd_we[k]    = we;
        bus.id_mem_read[k] = ld;
        bus.id_long[k]     = lg;
        bus.id_long_lat[k] = LW'(lat);
    endtask

    task automatic set_st(input int s, input int k, input bit v, input bit we, input int rd);
        bus.st_valid[s][k] = v;
        bus.st_rd_we[s][k] = we;
        bus.st_rd[s][k]    = RW'(rd);
    endtask

    initial begin
        rst_n = 1'b0;
        model_clear();
        clear_inputs();

        // reset: empty scoreboard, outputs still follow inputs combinationally
        sample("reset");
        check("reset_busy", bus.sb_busy, 16'h0000);
        advance();
        set_slot(0, 1, 1, 1, 2, 1, 0, 0, 0);
        set_slot(1, 1, 2, 0, 3, 1, 0, 0, 0);
        sample("reset_comb");
        check("reset_comb_mask", bus.issue_mask, 2'b01);
        advance();
        rst_n = 1'b1;
        clear_inputs();

        // load r3 then dependent: one stall cycle, then forward from MEM slot 0
        set_slot(0, 1, 1, 0, 3, 1, 1, 0, 0);
        sample("ld_issue");
        check("ld_issue_mask", bus.issue_mask, 2'b01);
        advance();
        set_slot(0, 1, 3, 0, 6, 1, 0, 0, 0);
        sample("ld_use");
        check("ld_use_stall", bus.stall, 1'b1);
        check("ld_use_busy3", bus.sb_busy[3], 1'b1);
        advance();
        set_st(1, 0, 1, 1, 3);
        sample("ld_fwd");
        check("ld_fwd_stall", bus.stall, 1'b0);
        check("ld_fwd_code", bus.fwd_a[0], 3'd3);
        advance();
        clear_inputs();

        // long op r5 latency 4: dependent stalls four cycles
        set_slot(0, 1, 1, 1, 5, 1, 0, 1, 4);
        sample("long_issue");
        advance();
        set_slot(0, 1, 5, 0, 6, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            sample("long_wait");
            check("long_wait_stall", bus.stall, 1'b1);
            check("long_wait_busy5", bus.sb_busy[5], 1'b1);
            advance();
        end
        sample("long_go");
        check("long_go_stall", bus.stall, 1'b0);
        check("long_go_busy5", bus.sb_busy[5], 1'b0);
        check("long_go_mask", bus.issue_mask, 2'b01);
        advance();
        clear_inputs();

        // intra-bundle RAW: split, then the consumer forwards from EX slot 0
        set_slot(0, 1, 1, 1, 2, 1, 0, 0, 0);
        set_slot(1, 1, 2, 0, 8, 1, 0, 0, 0);
        sample("split");
        check("split_mask", bus.issue_mask, 2'b01);
        check("split_flag", bus.split, 1'b1);
        advance();
        clear_inputs();
        set_slot(0, 1, 2, 0, 8, 1, 0, 0, 0);
        set_st(0, 0, 1, 1, 2);
        sample("split_next");
        check("split_next_fwd", bus.fwd_a[0], 3'd1);
        check("split_next_mask", bus.issue_mask, 2'b01);
        advance();
        clear_inputs();

        // priority: EX1 over MEM0 over lc; r0 reads the register file
        set_st(0, 1, 1, 1, 4);
        set_st(1, 0, 1, 1, 4);
        set_st(2, 1, 1, 1, 0);
        bus.lc_valid = 1'b1;
        bus.lc_rd    = RW'(4);
        set_slot(0, 1, 4, 0, 9, 1, 0, 0, 0);
        set_slot(1, 1, 0, 4, 10, 1, 0, 0, 0);
        sample("prio");
        check("prio_a0", bus.fwd_a[0], 3'd2);
        check("prio_b0", bus.fwd_b[0], 3'd0);
        check("prio_b1", bus.fwd_b[1], 3'd2);
        advance();
        bus.st_valid = '0;
        sample("prio_lc");
        check("prio_lc_a0", bus.fwd_a[0], 3'd7);
        advance();
        clear_inputs();

        // hold freezes the countdown; flush blocks issue but countdown continues
        set_slot(0, 1, 1, 1, 7, 1, 0, 1, 2);
        sample("hold_issue");
        advance();
        set_slot(0, 1, 7, 0, 9, 1, 0, 0, 0);
        bus.pipe_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample("hold");
            check("hold_busy7", bus.sb_busy[7], 1'b1);
            check("hold_mask", bus.issue_mask, 2'b00);
            advance();
        end
        bus.pipe_hold = 1'b0;
        bus.flush     = 1'b1;
        sample("flush");
        check("flush_mask", bus.issue_mask, 2'b00);
        check("flush_busy7", bus.sb_busy[7], 1'b1);
        advance();
        bus.flush = 1'b0;
        sample("after_flush");
        check("after_flush_stall", bus.stall, 1'b1);
        advance();
        sample("after_flush_go");
        check("after_flush_go_stall", bus.stall, 1'b0);
        advance();
        clear_inputs();

        // latency 0 is treated as 1; latency 15 clamps to MAX_LAT
        set_slot(0, 1, 1, 1, 10, 1, 0, 1, 0);
        sample("lat0_issue");
        advance();
        set_slot(0, 1, 10, 0, 11, 1, 0, 0, 0);
        sample("lat0_wait");
        check("lat0_stall", bus.stall, 1'b1);
        advance();
        sample("lat0_go");
        check("lat0_go_stall", bus.stall, 1'b0);
        advance();
        clear_inputs();
        set_slot(0, 1, 1, 1, 12, 1, 0, 1, 15);
        sample("lat15_issue");
        advance();
        set_slot(0, 1, 12, 0, 13, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            sample("lat15_wait");
            advance();
        end
        clear_inputs();

        // asynchronous reset mid-countdown
        set_slot(0, 1, 1, 1, 9, 1, 0, 1, 8);
        sample("rst_issue");
        advance();
        clear_inputs();
        sample("rst_count");
        advance();
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("async_rst_busy", bus.sb_busy, 16'h0000);
        sample("in_reset");
        check("in_reset_perf", bus.perf_stall, 32'd0);
        advance();
        rst_n = 1'b1;

        // random bundles
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < ISSUE_W; k++) begin
                bit ld, lg;
                ld = ($urandom_range(0, 3) == 0);
                lg = !ld && ($urandom_range(0, 5) == 0);
                set_slot(k, $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 7), $urandom_range(0, 3) != 0, ld, lg,
                         $urandom_range(0, 15));
            end
            for (int s = 0; s < STAGES; s++)
                for (int k = 0; k < ISSUE_W; k++)
                    set_st(s, k, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                           $urandom_range(0, 7));
            bus.lc_valid  = ($urandom_range(0, 3) == 0);
            bus.lc_rd     = RW'($urandom_range(0, 7));
            bus.pipe_hold = ($urandom_range(0, 9) == 0);
            bus.flush     = ($urandom_range(0, 9) == 0);
            sample("rand");
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
